gaussian_nb_mac_pipe: RTL and testbench

//   Parametrised pipelined signed multiplier/accumulator for the gaussian_nb datapath.

---
 rtl/gaussian_nb_mac_pipe.sv | 158 +++++++++++++++
 tb/tb_gaussian_nb_mac_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_nb_mac_pipe.sv
// Pipelined signed multiply/accumulate with valid/last sideband, optional group accumulation,
// arithmetic output shift and saturation. Latency is NUM_STAGE ce-cycles; ce=0 freezes everything.
module gaussian_nb_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 21,
  parameter int ACC_WIDTH  = 48,
  parameter int DOUT_WIDTH = 37,
  parameter int SHIFT      = 0,
  parameter int NUM_STAGE  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic                  acc_en,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat_flag
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
  localparam int MID        = NUM_STAGE - 2;

  localparam logic signed [ACC_WIDTH-1:0] DMAX =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DMIN =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  // Stage 1: registered operands and sideband.
  logic                         s1_valid, s1_last, s1_acc;
  logic signed [DIN0_WIDTH-1:0] s1_a;
  logic signed [DIN1_WIDTH-1:0] s1_b;
  logic signed [PROD_WIDTH-1:0] prod_full;
  logic signed [ACC_WIDTH-1:0]  prod_ext;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
    end else if (ce) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: datapath registers carry no reset; only the valid bits qualify their contents,
  // so resetting the data would add fan-out to the reset net for no functional gain.
  always_ff @(posedge clk) begin
    if (ce) begin
      s1_last <= in_last;
      s1_acc  <= acc_en;
      s1_a    <= din0;
      s1_b    <= din1;
    end
  end

  assign prod_full = PROD_WIDTH'(s1_a) * PROD_WIDTH'(s1_b);
  assign prod_ext  = ACC_WIDTH'(prod_full);

  // Tail of the product pipeline, feeding the accumulate/output stage.
  logic                        t_valid, t_last, t_acc;
  logic signed [ACC_WIDTH-1:0] t_prod;

  generate
    if (MID == 0) begin : g_direct
      assign t_valid = s1_valid;
      assign t_last  = s1_last;
      assign t_acc   = s1_acc;
      assign t_prod  = prod_ext;
    end else begin : g_mid
      logic [MID-1:0]              mid_valid, mid_last, mid_acc;
      logic signed [ACC_WIDTH-1:0] mid_prod [MID];

      always_ff @(posedge clk) begin
        if (!reset) begin
          mid_valid <= '0;
        end else if (ce) begin
          mid_valid[0] <= s1_valid;
          for (int i = 1; i < MID; i++) mid_valid[i] <= mid_valid[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (ce) begin
          mid_last[0] <= s1_last;
          mid_acc[0]  <= s1_acc;
          mid_prod[0] <= prod_ext;
          for (int i = 1; i < MID; i++) begin
            mid_last[i] <= mid_last[i-1];
            mid_acc[i]  <= mid_acc[i-1];
            mid_prod[i] <= mid_prod[i-1];
          end
        end
      end

      assign t_valid = mid_valid[MID-1];
      assign t_last  = mid_last[MID-1];
      assign t_acc   = mid_acc[MID-1];
      assign t_prod  = mid_prod[MID-1];
    end
  endgenerate

  // Final stage: group sum, shift and clamp.
  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum, res, shifted;
  logic                        sat_hi, sat_lo;
  logic [DOUT_WIDTH-1:0]       res_sat;

  always_comb begin
    sum     = (state == RUN) ? acc + t_prod : t_prod;
    res     = t_acc ? sum : t_prod;
    shifted = res >>> SHIFT;
    sat_hi  = shifted > DMAX;
    sat_lo  = shifted < DMIN;
    if (sat_hi)      res_sat = DMAX[DOUT_WIDTH-1:0];
    else if (sat_lo) res_sat = DMIN[DOUT_WIDTH-1:0];
    else             res_sat = shifted[DOUT_WIDTH-1:0];
  end

  // NOTE: all state here uses non-blocking assignment so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
      dout      <= '0;
    end else if (ce) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
      if (t_valid && !t_acc) begin
        out_valid <= 1'b1;
        dout      <= res_sat;
        sat_flag  <= sat_hi | sat_lo;
      end else if (t_valid) begin
        acc <= sum;
        if (t_last) begin
          out_valid <= 1'b1;
          out_last  <= 1'b1;
          dout      <= res_sat;
          sat_flag  <= sat_hi | sat_lo;
          state     <= IDLE;
        end else begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_gaussian_nb_mac_pipe.sv
// Bench for gaussian_nb_mac_pipe: two configurations share stimulus and are compared each
// cycle against a beat-level model (products, group sums, clamp) plus directed scenarios.
module tb_gaussian_nb_mac_pipe;

  localparam int NS = 4;
  localparam int WA = 37, SHA = 0;
  localparam int WB = 20, SHB = 4;

  logic clk = 1'b0;
  logic reset, ce, in_valid, in_last, acc_en;
  logic [15:0] din0;
  logic [20:0] din1;
  logic va, la, sa, vb, lb, sb;
  logic [WA-1:0] da;
  logic [WB-1:0] db;

  always #5 clk = ~clk;

  gaussian_nb_mac_pipe dut_a (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .acc_en(acc_en), .din0(din0), .din1(din1),
    .out_valid(va), .out_last(la), .dout(da), .sat_flag(sa)
  );

  gaussian_nb_mac_pipe #(.DOUT_WIDTH(WB), .SHIFT(SHB)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .acc_en(acc_en), .din0(din0), .din1(din1),
    .out_valid(vb), .out_last(lb), .dout(db), .sat_flag(sb)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sat_val(input longint v, input int w, input int sh);
    longint t  = v >>> sh;
    longint mx = (64'sd1 <<< (w - 1)) - 1;
    if (t > mx) return mx;
    if (t < -mx - 1) return -mx - 1;
    return t;
  endfunction

  function automatic bit sat_hit(input longint v, input int w, input int sh);
    return sat_val(v, w, sh) != (v >>> sh);
  endfunction

  typedef struct {
    longint da; bit sa; longint db; bit sb; bit last; int due;
  } exp_t;

  exp_t q[$];
  logic signed [47:0] grp_sum;
  bit     grp_run = 0;
  int     ce_cnt = 0;
  int     edge_kind = 0;   // 0 reset, 1 enabled edge, 2 stalled edge
  bit     started = 0;
  longint pv;

  function automatic exp_t mk(input longint v, input bit l, input int due);
    exp_t e;
    e.da = sat_val(v, WA, SHA); e.sa = sat_hit(v, WA, SHA);
    e.db = sat_val(v, WB, SHB); e.sb = sat_hit(v, WB, SHB);
    e.last = l; e.due = due;
    return e;
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (!reset) begin
      q.delete();
      grp_run = 0;
      grp_sum = '0;
      edge_kind = 0;
    end else if (!ce) begin
      edge_kind = 2;
    end else begin
      edge_kind = 1;
      ce_cnt++;
      if (in_valid) begin
        pv = longint'($signed(din0)) * longint'($signed(din1));
        if (!acc_en) begin
          q.push_back(mk(pv, 1'b0, ce_cnt + NS - 1));
        end else begin
          grp_sum = (grp_run ? grp_sum : 48'sd0) + 48'(pv);
          if (in_last) begin
            q.push_back(mk(longint'(grp_sum), 1'b1, ce_cnt + NS - 1));
            grp_run = 0;
          end else begin
            grp_run = 1;
          end
        end
      end
    end
  end

  // Expected output registers of the model (held across stalls and idle cycles).
  bit ev, el, esa, esb;
  longint eda, edb;
  exp_t ecur;

  always @(negedge clk) begin
    if (started) begin
      if (edge_kind == 0) begin
        ev = 0; el = 0; esa = 0; esb = 0; eda = 0; edb = 0;
      end else if (edge_kind == 1) begin
        if (q.size() > 0 && q[0].due == ce_cnt) begin
          ecur = q.pop_front();
          ev = 1; el = ecur.last; eda = ecur.da; esa = ecur.sa; edb = ecur.db; esb = ecur.sb;
        end else begin
          ev = 0; el = 0; esa = 0; esb = 0;
        end
      end
      check("a_valid", va, ev);
      check("a_last", la, el);
      check("a_dout", $signed(da), eda);
      check("a_sat", sa, esa);
      check("b_valid", vb, ev);
      check("b_last", lb, el);
      check("b_dout", $signed(db), edb);
      check("b_sat", sb, esb);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input bit v, input bit l, input bit a, input longint x,
                        input longint y, input bit c);
    in_valid = v; in_last = l; acc_en = a; ce = c;
    din0 = 16'(x); din1 = 21'(y);
  endtask

  task automatic beat(input bit v, input bit l, input bit a, input longint x,
                      input longint y, input bit c);
    set_in(v, l, a, x, y, c);
    @(negedge clk);
  endtask

  // Returns the number of further negedges until out_valid is seen (0 on timeout).
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (va === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  longint rx, ry;

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Multiply latency: captured at edge 1, visible after edge 4.
    beat(1, 0, 0, -3, 1000, 1);
    set_in(0, 0, 0, 0, 0, 1);
    wait_valid(n);
    check("mul_latency", 1 + n, NS);
    check("mul_dout", $signed(da), -3000);
    check("mul_last", la, 0);

    // Back-to-back multiplies with two stalled cycles.
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 5) beat(0, 0, 0, 0, 0, 0);
      beat(1, 0, 0, i, 2, 1);
    end
    repeat (8) beat(0, 0, 0, 0, 0, 1);

    // Accumulation group of four beats.
    beat(1, 0, 1, 1, 2, 1);
    beat(1, 0, 1, 3, 4, 1);
    beat(1, 0, 1, 5, 6, 1);
    beat(1, 1, 1, 7, 8, 1);
    set_in(0, 0, 0, 0, 0, 1);
    wait_valid(n);
    check("acc_latency", 1 + n, NS);
    check("acc_dout", $signed(da), 100);
    check("acc_last", la, 1);
    check("acc_dout_shift", $signed(db), 6);
    repeat (4) @(negedge clk);

    // Saturation in the narrow configuration.
    beat(1, 0, 0, 32767, 1048575, 1);
    set_in(0, 0, 0, 0, 0, 1);
    wait_valid(n);
    check("sat_pos_dout", $signed(db), 524287);
    check("sat_pos_flag", sb, 1);
    beat(1, 0, 0, -32768, 1048575, 1);
    set_in(0, 0, 0, 0, 0, 1);
    wait_valid(n);
    check("sat_neg_dout", $signed(db), -524288);
    check("sat_neg_flag", sb, 1);
    check("nosat_wide", sa, 0);

    // Reset in the middle of a group discards the partial sum.
    beat(1, 0, 1, 9, 9, 1);
    beat(1, 0, 1, 9, 9, 1);
    set_in(0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    beat(1, 1, 1, 2, 5, 1);
    set_in(0, 0, 0, 0, 0, 1);
    wait_valid(n);
    check("rst_grp_latency", 1 + n, NS);
    check("rst_grp_dout", $signed(da), 10);
    check("rst_grp_last", la, 1);

    // Floor shift and a multiply interleaved inside a group.
    beat(1, 0, 0, -1, 17, 1);
    set_in(0, 0, 0, 0, 0, 1);
    wait_valid(n);
    check("shift_neg", $signed(db), -2);
    beat(1, 0, 1, 1, 1, 1);
    beat(1, 0, 0, 3, 3, 1);
    beat(1, 1, 1, 2, 2, 1);
    set_in(0, 0, 0, 0, 0, 1);
    wait_valid(n);
    check("ilv_mul_b", $signed(db), 0);
    check("ilv_mul_a", $signed(da), 9);
    wait_valid(n);
    check("ilv_grp_a", $signed(da), 5);
    check("ilv_grp_last", la, 1);
    repeat (4) @(negedge clk);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 127) != 0);
      case ($urandom_range(0, 7))
        0: rx = 32767;
        1: rx = -32768;
        default: rx = longint'($signed(16'($urandom)));
      endcase
      case ($urandom_range(0, 7))
        0: ry = 1048575;
        1: ry = -1048576;
        default: ry = longint'($signed(21'($urandom)));
      endcase
      beat($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           rx, ry, $urandom_range(0, 19) < 17);
    end
    reset = 1'b1;
    repeat (10) beat(0, 0, 0, 0, 0, 1);
    check("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
